// File: rtl/led_ctrl_frontend_pkg.sv
// Shared constants for the LED controller: timebase phase width, slow-tick
// divider and the default conditioning/timebase widths.
package led_ctrl_frontend_pkg;

    localparam int PHASE_W      = 2;
    localparam int SLOW_DIV     = 4;
    localparam int SAMPLE_W_DEF = 16;
    localparam int DB_LEN_DEF   = 4;
    localparam int TICK_W_DEF   = 23;

    typedef logic [PHASE_W-1:0] phase_t;

    localparam phase_t PHASE_LAST = phase_t'(SLOW_DIV - 1);

    // Registered single-cycle strobes leaving the frontend.
    typedef struct packed {
        logic tick;
        logic tick_slow;
        logic clr;
    } strobe_t;

endpackage

// File: rtl/led_ctrl_frontend_btn_debounce.sv
// Per-input conditioning: 2-flop synchronizer, sampled shift-register debounce
// and a one-cycle pulse on each rising edge of the debounced level.
module btn_debounce
    import led_ctrl_frontend_pkg::*;
#(
    parameter int DB_LEN = DB_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic samp,
    output logic level,
    output logic press
);

    logic [1:0]        sync_q, sync_d;
    logic [DB_LEN-1:0] hist_q, hist_d;
    logic              level_q, level_d;
    logic              level_dly_q, level_dly_d;

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path leaves it unassigned and no latch is inferred.
        sync_d      = {sync_q[0], raw};
        hist_d      = hist_q;
        level_d     = level_q;
        level_dly_d = level_q;

        if (samp) begin
            hist_d = (hist_q << 1) | DB_LEN'(sync_q[1]);
        end
        if (&hist_q) begin
            level_d = 1'b1;
        end else if (~|hist_q) begin
            level_d = 1'b0;
        end

        // NOTE: reset is synchronous, so it is simply the highest-priority term of each next-state value.
        if (rst) begin
            sync_d      = '0;
            hist_d      = '0;
            level_d     = 1'b0;
            level_dly_d = 1'b0;
        end
    end

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        sync_q      <= sync_d;
        hist_q      <= hist_d;
        level_q     <= level_d;
        level_dly_q <= level_dly_d;
    end

    assign level = level_q;
    assign press = level_q & ~level_dly_q;

endmodule

// File: rtl/led_ctrl_frontend.sv
// Input conditioning and timebase for the bouncing-LED engine: debounced
// buttons/switch, en toggle, tick-aligned clear and tick/tick_slow enables.
module led_ctrl_frontend
    import led_ctrl_frontend_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int DB_LEN   = DB_LEN_DEF,
    parameter int TICK_W   = TICK_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_en_raw,
    input  logic btn_clr_raw,
    input  logic sw_speed_raw,
    output logic en,
    output logic speed,
    output logic clr,
    output logic tick,
    output logic tick_slow
);

    logic [SAMPLE_W-1:0] scnt_q, scnt_d;
    logic                samp_q, samp_d;
    logic [TICK_W-1:0]   tcnt_q, tcnt_d;
    phase_t              phase_q, phase_d;
    strobe_t             strb_q, strb_d;
    logic                en_q, en_d;
    logic                clr_pend_q, clr_pend_d;
    logic                speed_q, speed_d;

    logic en_press, clr_press, spd_level;
    logic unused_en_level, unused_clr_level, unused_spd_press;

    btn_debounce #(.DB_LEN(DB_LEN)) u_db_en (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_en_raw),
        .samp  (samp_q),
        .level (unused_en_level),
        .press (en_press)
    );

    btn_debounce #(.DB_LEN(DB_LEN)) u_db_clr (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_clr_raw),
        .samp  (samp_q),
        .level (unused_clr_level),
        .press (clr_press)
    );

    btn_debounce #(.DB_LEN(DB_LEN)) u_db_speed (
        .clk   (clk),
        .rst   (rst),
        .raw   (sw_speed_raw),
        .samp  (samp_q),
        .level (spd_level),
        .press (unused_spd_press)
    );

    // Strobes are computed from next-state values so each output flop is high
    // exactly in the cycle its counter condition holds.
    always_comb begin
        scnt_d     = scnt_q + 1'b1;
        samp_d     = (scnt_d == '1);
        tcnt_d     = tcnt_q + 1'b1;
        en_d       = en_q ^ en_press;
        clr_pend_d = clr_press | (clr_pend_q & ~strb_q.clr);

        phase_d = phase_q;
        if (strb_q.tick) begin
            phase_d = strb_q.clr ? '0 : phase_q + 1'b1;
        end

        strb_d.tick      = (tcnt_d == '1);
        strb_d.tick_slow = strb_d.tick & (phase_d == PHASE_LAST);
        strb_d.clr       = strb_d.tick & clr_pend_d;
        speed_d          = strb_d.tick_slow ? spd_level : speed_q;

        if (rst) begin
            scnt_d     = '0;
            samp_d     = 1'b0;
            tcnt_d     = '0;
            en_d       = 1'b0;
            clr_pend_d = 1'b0;
            phase_d    = '0;
            strb_d     = '0;
            speed_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        scnt_q     <= scnt_d;
        samp_q     <= samp_d;
        tcnt_q     <= tcnt_d;
        phase_q    <= phase_d;
        strb_q     <= strb_d;
        en_q       <= en_d;
        clr_pend_q <= clr_pend_d;
        speed_q    <= speed_d;
    end

    assign en        = en_q;
    assign speed     = speed_q;
    assign clr       = strb_q.clr;
    assign tick      = strb_q.tick;
    assign tick_slow = strb_q.tick_slow;

endmodule
